// File: rtl/fetch_pipe_ctrl_pkg.sv
// Shared front-end encodings and constants for the fetch pipeline controller.
package fetch_pipe_ctrl_pkg;

  typedef enum logic [1:0] {
    FE_RUN   = 2'd0,
    FE_STALL = 2'd1,
    FE_FLUSH = 2'd2,
    FE_HALT  = 2'd3
  } fe_state_e;

  localparam logic [31:0] FE_NOP_INSTR = 32'h0000_0000;
  localparam logic [31:0] FE_ALIGN_MASK = 32'hFFFF_FFFC;

endpackage

// File: rtl/fetch_pipe_ctrl_sat_counter.sv
// Increment-enable counter that sticks at all-ones instead of wrapping.
module sat_counter #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         inc,
  output logic [W-1:0] cnt
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)            cnt <= '0;
    else if (inc && !(&cnt)) cnt <= cnt + 1'b1;
  end

endmodule

// File: rtl/fetch_pipe_ctrl.sv
// Front-end controller: owns PC and IF/ID, applies halt/stall/flush, counts stalls and flushes.
module fetch_pipe_ctrl
  import fetch_pipe_ctrl_pkg::*;
#(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = FE_NOP_INSTR,
  parameter int          CNT_W     = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             data_hazard,
  input  logic             if_flush,
  input  logic [31:0]      redirect_pc,
  input  logic             halt,
  input  logic [31:0]      instr_in,
  output logic [31:0]      pc_out,
  output logic [31:0]      if_id_instr,
  output logic [31:0]      if_id_pc4,
  output logic             if_id_valid,
  output logic             id_ex_bubble,
  output logic [1:0]       fe_state,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  fe_state_e   act, state_q;
  logic [31:0] pc_plus4;

  // Stall masks flush: branch operands are not valid while a load-use hazard is pending.
  always_comb begin
    act = FE_RUN;
    if (halt)              act = FE_HALT;
    else if (!data_hazard) act = FE_STALL;
    else if (if_flush)     act = FE_FLUSH;
  end

  assign pc_plus4     = pc_out + 32'd4;
  assign id_ex_bubble = ~halt & ~data_hazard;
  assign fe_state     = state_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_out      <= RESET_PC;
      if_id_instr <= NOP_INSTR;
      if_id_pc4   <= '0;
      if_id_valid <= 1'b0;
      state_q     <= FE_RUN;
    end else begin
      state_q <= act;
      case (act)
        FE_RUN: begin
          pc_out      <= pc_plus4;
          if_id_instr <= instr_in;
          if_id_pc4   <= pc_plus4;
          if_id_valid <= 1'b1;
        end
        FE_FLUSH: begin
          pc_out      <= redirect_pc & FE_ALIGN_MASK;
          if_id_instr <= NOP_INSTR;
          if_id_pc4   <= '0;
          if_id_valid <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  sat_counter #(.W(CNT_W)) u_stall_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (act == FE_STALL),
    .cnt   (stall_cnt)
  );

  sat_counter #(.W(CNT_W)) u_flush_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (act == FE_FLUSH),
    .cnt   (flush_cnt)
  );

endmodule

// File: tb/tb_fetch_pipe_ctrl.sv
// Directed + randomized check of fetch_pipe_ctrl against a rule-level reference model.
module tb_fetch_pipe_ctrl;

  localparam logic [31:0] RST_PC = 32'h0000_0400;
  localparam int          CW     = 4;
  localparam int          CMAX   = (1 << CW) - 1;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          data_hazard, if_flush, halt;
  logic [31:0]   redirect_pc, instr_in;
  logic [31:0]   pc_out, if_id_instr, if_id_pc4;
  logic          if_id_valid, id_ex_bubble;
  logic [1:0]    fe_state;
  logic [CW-1:0] stall_cnt, flush_cnt;

  int n_chk  = 0;
  int n_fail = 0;

  // reference model state
  logic [31:0] m_pc, m_instr, m_pc4;
  logic        m_valid;
  int          m_state, m_scnt, m_fcnt;

  fetch_pipe_ctrl #(.RESET_PC(RST_PC), .NOP_INSTR(32'h0000_0000), .CNT_W(CW)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .data_hazard  (data_hazard),
    .if_flush     (if_flush),
    .redirect_pc  (redirect_pc),
    .halt         (halt),
    .instr_in     (instr_in),
    .pc_out       (pc_out),
    .if_id_instr  (if_id_instr),
    .if_id_pc4    (if_id_pc4),
    .if_id_valid  (if_id_valid),
    .id_ex_bubble (id_ex_bubble),
    .fe_state     (fe_state),
    .stall_cnt    (stall_cnt),
    .flush_cnt    (flush_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_pc = RST_PC; m_instr = 32'h0; m_pc4 = 32'h0; m_valid = 1'b0;
    m_state = 0; m_scnt = 0; m_fcnt = 0;
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".pc"},    pc_out,      m_pc);
    chk({tag, ".instr"}, if_id_instr, m_instr);
    chk({tag, ".pc4"},   if_id_pc4,   m_pc4);
    chk({tag, ".valid"}, {31'b0, if_id_valid}, {31'b0, m_valid});
    chk({tag, ".state"}, {30'b0, fe_state},    m_state);
    chk({tag, ".scnt"},  {28'b0, stall_cnt},   m_scnt);
    chk({tag, ".fcnt"},  {28'b0, flush_cnt},   m_fcnt);
  endtask

  // Drive one cycle from the negedge, check the bubble before the edge and all state after it.
  task automatic cyc(input logic h, input logic dh, input logic fl,
                     input logic [31:0] rp, input logic [31:0] ins);
    halt = h; data_hazard = dh; if_flush = fl; redirect_pc = rp; instr_in = ins;
    #1;
    chk("bubble", {31'b0, id_ex_bubble}, {31'b0, (!h && !dh)});
    @(posedge clk);
    if (h) begin
      m_state = 3;
    end else if (!dh) begin
      m_state = 1;
      if (m_scnt < CMAX) m_scnt++;
    end else if (fl) begin
      m_state = 2;
      m_pc = {rp[31:2], 2'b00};
      m_instr = 32'h0; m_pc4 = 32'h0; m_valid = 1'b0;
      if (m_fcnt < CMAX) m_fcnt++;
    end else begin
      m_state = 0;
      m_instr = ins;
      m_pc = m_pc + 32'd4;
      m_pc4 = m_pc;
      m_valid = 1'b1;
    end
    #1;
    check_all("cyc");
    @(negedge clk);
  endtask

  initial begin
    rst_n = 1'b0; halt = 1'b0; data_hazard = 1'b1; if_flush = 1'b0;
    redirect_pc = 32'h0; instr_in = 32'h0;
    model_reset();
    repeat (2) @(negedge clk);
    check_all("reset");
    rst_n = 1'b1;

    // three fetches from RESET_PC
    cyc(0, 1, 0, 32'h0, 32'h11);
    cyc(0, 1, 0, 32'h0, 32'h22);
    cyc(0, 1, 0, 32'h0, 32'h33);
    chk("run3.pc", pc_out, 32'h40C);
    chk("run3.instr", if_id_instr, 32'h33);
    chk("run3.pc4", if_id_pc4, 32'h40C);

    // two-cycle load-use stall
    cyc(0, 0, 0, 32'h0, 32'h44);
    cyc(0, 0, 0, 32'h0, 32'h44);
    chk("stall.pc", pc_out, 32'h40C);
    chk("stall.cnt", {28'b0, stall_cnt}, 32'd2);

    // flush with misaligned target
    cyc(0, 1, 1, 32'h1003, 32'h55);
    chk("flush.pc", pc_out, 32'h1000);
    chk("flush.cnt", {28'b0, flush_cnt}, 32'd1);

    // stall masks flush, then flush applies
    cyc(0, 0, 1, 32'h2000, 32'h66);
    chk("mask.fcnt", {28'b0, flush_cnt}, 32'd1);
    cyc(0, 1, 1, 32'h2000, 32'h66);
    chk("unmask.pc", pc_out, 32'h2000);

    // consecutive flushes, then pc wrap
    cyc(0, 1, 1, 32'h3000, 32'h0);
    cyc(0, 1, 1, 32'hFFFF_FFFF, 32'h0);
    cyc(0, 1, 0, 32'h0, 32'h77);
    chk("wrap.pc", pc_out, 32'h0);
    chk("wrap.pc4", if_id_pc4, 32'h0);

    // halt holds everything
    cyc(1, 0, 1, 32'h5000, 32'h88);
    cyc(1, 1, 0, 32'h5000, 32'h88);

    // stall counter saturation
    for (int i = 0; i < 20; i++) cyc(0, 0, 0, 32'h0, 32'h99);
    chk("sat.scnt", {28'b0, stall_cnt}, 32'hF);

    // randomized traffic with occasional reset to exercise counters below saturation
    for (int i = 0; i < 400; i++) begin
      if (i % 100 == 50) begin
        rst_n = 1'b0; #1; model_reset(); check_all("rrst");
        @(negedge clk); rst_n = 1'b1;
      end
      cyc($urandom_range(0, 9) == 0, $urandom_range(0, 3) != 0,
          $urandom_range(0, 4) == 0, $urandom, $urandom);
    end

    // async reset mid-stall with halt, checked before any clock edge
    cyc(0, 0, 0, 32'h0, 32'h0);
    halt = 1'b1; data_hazard = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    check_all("arst");
    @(negedge clk);
    halt = 1'b0; data_hazard = 1'b1;
    rst_n = 1'b1;
    cyc(0, 1, 0, 32'h0, 32'hAB);
    chk("post.pc", pc_out, RST_PC + 32'd4);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
